// File: rtl/sync_data_memory_if.sv
// sync_data_memory_if: load/store bus between the control unit (master) and
// the synchronous data memory (slave).
//   memIn       master->slave  write data
//   lineNumber  master->slave  line address for read and write
//   memRead     master->slave  read request
//   memWrite    master->slave  write request
//   memClear    master->slave  request a full zeroing sweep
//   memOut      slave->master  registered read data
//   memValid    slave->master  memOut updated this cycle
//   memReady    slave->master  requests accepted
//   memError    slave->master  previous accepted access was out of range
interface sync_data_memory_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] memIn;
   logic [ADDR_WIDTH-1:0] lineNumber;
   logic                  memRead;
   logic                  memWrite;
   logic                  memClear;
   logic [DATA_WIDTH-1:0] memOut;
   logic                  memValid;
   logic                  memReady;
   logic                  memError;

   modport master (
      output memIn, lineNumber, memRead, memWrite, memClear,
      input  memOut, memValid, memReady, memError
   );

   modport slave (
      input  memIn, lineNumber, memRead, memWrite, memClear,
      output memOut, memValid, memReady, memError
   );
endinterface

// File: rtl/sync_data_memory.sv
// sync_data_memory: parametrised synchronous data memory with registered read
// port, valid strobe, out-of-range error strobe and a hardware clear sweep
// that zeroes every line after reset or on request.
//   clk      clock, all state changes on the rising edge
//   reset    asynchronous active-high reset; restarts the clear sweep
//   mem_bus  slave side of sync_data_memory_if (requests in, data/status out)
module sync_data_memory #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DEPTH      = 256
) (
   input  logic              clk,
   input  logic              reset,
   sync_data_memory_if.slave mem_bus
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CMP_W = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0] LAST_LINE = PTR_W'(DEPTH - 1);
   localparam logic [CMP_W-1:0] DEPTH_C   = CMP_W'(DEPTH);

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      clr_ptr_q, clr_ptr_d;
   logic [DATA_WIDTH-1:0] mem_out_q, mem_out_d;
   logic                  mem_valid_q, mem_valid_d;
   logic                  mem_ready_q, mem_ready_d;
   logic                  mem_error_q, mem_error_d;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  we_c;
   logic [PTR_W-1:0]      waddr_c;
   logic [DATA_WIDTH-1:0] wdata_c;
   logic                  in_range_c;
   logic [PTR_W-1:0]      line_idx_c;

   // Extra MSB on the compare so DEPTH == 2^ADDR_WIDTH is representable.
   assign in_range_c = ({1'b0, mem_bus.lineNumber} < DEPTH_C);
   // PTR_W <= ADDR_WIDTH; truncated index is only used when in range.
   assign line_idx_c = PTR_W'(mem_bus.lineNumber);

   // Next-state, array write port and output next values.
   always_comb begin
      state_d     = state_q;
      clr_ptr_d   = clr_ptr_q;
      mem_out_d   = mem_out_q;
      mem_valid_d = 1'b0;
      mem_error_d = 1'b0;
      we_c        = 1'b0;
      waddr_c     = clr_ptr_q;
      wdata_c     = '0;

      case (state_q)
         CLEAR: begin
            we_c    = 1'b1;
            waddr_c = clr_ptr_q;
            wdata_c = '0;
            if (clr_ptr_q == LAST_LINE) begin
               clr_ptr_d = '0;
               state_d   = IDLE;
            end else begin
               clr_ptr_d = clr_ptr_q + PTR_W'(1);
            end
         end
         IDLE: begin
            if (mem_bus.memClear) begin
               // Clear wins; any access in the same cycle is dropped silently.
               state_d   = CLEAR;
               clr_ptr_d = '0;
            end else begin
               if (mem_bus.memWrite && in_range_c) begin
                  we_c    = 1'b1;
                  waddr_c = line_idx_c;
                  wdata_c = mem_bus.memIn;
               end
               if (mem_bus.memRead) begin
                  mem_valid_d = 1'b1;
                  if (!in_range_c) begin
                     mem_out_d = '0;
                  end else if (mem_bus.memWrite) begin
                     // Write-first on a same-line read/write.
                     mem_out_d = mem_bus.memIn;
                  end else begin
                     mem_out_d = mem_q[line_idx_c];
                  end
               end
               mem_error_d = (mem_bus.memRead || mem_bus.memWrite) && !in_range_c;
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase

      mem_ready_d = (state_d == IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= CLEAR;
         clr_ptr_q   <= '0;
         mem_out_q   <= '0;
         mem_valid_q <= 1'b0;
         mem_ready_q <= 1'b0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         mem_out_q   <= mem_out_d;
         mem_valid_q <= mem_valid_d;
         mem_ready_q <= mem_ready_d;
         mem_error_q <= mem_error_d;
      end
   end

   // Storage array; deliberately not reset, the clear sweep zeroes it.
   always_ff @(posedge clk) begin
      if (we_c) begin
         mem_q[waddr_c] <= wdata_c;
      end
   end

   assign mem_bus.memOut   = mem_out_q;
   assign mem_bus.memValid = mem_valid_q;
   assign mem_bus.memReady = mem_ready_q;
   assign mem_bus.memError = mem_error_q;

endmodule

// File: tb/tb_sync_data_memory.sv
// tb_sync_data_memory: directed bench for sync_data_memory. Instance a uses
// DEPTH=256, instance b uses DEPTH=200 with ADDR_WIDTH=8 for out-of-range cases.
module tb_sync_data_memory;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   sync_data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus_a ();
   sync_data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus_b ();

   sync_data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256)) dut_a (
      .clk     (clk),
      .reset   (reset),
      .mem_bus (bus_a)
   );

   sync_data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200)) dut_b (
      .clk     (clk),
      .reset   (reset),
      .mem_bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int addrs[3];
      n_checks = 0;
      n_fail   = 0;
      addrs    = '{0, 128, 255};

      reset = 1'b1;
      bus_a.memIn = '0; bus_a.lineNumber = '0;
      bus_a.memRead = 1'b0; bus_a.memWrite = 1'b0; bus_a.memClear = 1'b0;
      bus_b.memIn = '0; bus_b.lineNumber = '0;
      bus_b.memRead = 1'b0; bus_b.memWrite = 1'b0; bus_b.memClear = 1'b0;

      tick();
      tick();
      check("rst_out",   32'(bus_a.memOut), 0);
      check("rst_valid", 32'(bus_a.memValid), 0);
      check("rst_ready", 32'(bus_a.memReady), 0);
      check("rst_error", 32'(bus_a.memError), 0);
      check("rst_ready_b", 32'(bus_b.memReady), 0);

      // Initial sweep: 256 edges for a, 200 for b.
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         check("sweep_ready_a", 32'(bus_a.memReady), 0);
         check("sweep_ready_b", 32'(bus_b.memReady), 32'(i >= 200));
         check("sweep_error_a", 32'(bus_a.memError), 0);
         tick();
      end
      check("ready_after_sweep", 32'(bus_a.memReady), 1);

      // Cleared lines read back zero, one valid pulse per read.
      for (int k = 0; k < 3; k++) begin
         bus_a.lineNumber = 8'(addrs[k]);
         bus_a.memRead = 1'b1;
         tick();
         bus_a.memRead = 1'b0;
         check("clr_rd_out",   32'(bus_a.memOut), 0);
         check("clr_rd_valid", 32'(bus_a.memValid), 1);
         check("clr_rd_error", 32'(bus_a.memError), 0);
         tick();
         check("clr_rd_valid_drop", 32'(bus_a.memValid), 0);
      end

      // Write A5 to line 3, read back next cycle.
      bus_a.memWrite = 1'b1; bus_a.lineNumber = 8'd3; bus_a.memIn = 8'hA5;
      tick();
      check("wr_no_valid", 32'(bus_a.memValid), 0);
      bus_a.memWrite = 1'b0; bus_a.memRead = 1'b1;
      tick();
      bus_a.memRead = 1'b0;
      check("wr_rd_out",   32'(bus_a.memOut), 32'h A5);
      check("wr_rd_valid", 32'(bus_a.memValid), 1);
      tick();
      check("wr_rd_valid_drop", 32'(bus_a.memValid), 0);
      check("wr_rd_hold",       32'(bus_a.memOut), 32'h A5);

      // Same-cycle read and write to line 7: write-first.
      bus_a.memWrite = 1'b1; bus_a.lineNumber = 8'd7; bus_a.memIn = 8'h11;
      tick();
      bus_a.memRead = 1'b1; bus_a.memIn = 8'h3C;
      tick();
      check("rw_same_out",   32'(bus_a.memOut), 32'h 3C);
      check("rw_same_valid", 32'(bus_a.memValid), 1);
      bus_a.memWrite = 1'b0; bus_a.memIn = 8'h00;
      tick();
      bus_a.memRead = 1'b0;
      check("rw_same_stored", 32'(bus_a.memOut), 32'h 3C);

      // Fill lines 0..3, then back-to-back reads keep memValid high.
      bus_a.memWrite = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_a.lineNumber = 8'(k);
         bus_a.memIn = 8'hC0 + 8'(k);
         tick();
      end
      bus_a.memWrite = 1'b0;
      bus_a.memRead = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_a.lineNumber = 8'(k);
         tick();
         check("b2b_out",   32'(bus_a.memOut), 32'h C0 + 32'(k));
         check("b2b_valid", 32'(bus_a.memValid), 1);
      end
      bus_a.memRead = 1'b0;
      tick();
      check("b2b_valid_drop", 32'(bus_a.memValid), 0);

      // memClear with write+read in the same cycle; requests held during sweep.
      bus_a.memClear = 1'b1; bus_a.memWrite = 1'b1; bus_a.memRead = 1'b1;
      bus_a.lineNumber = 8'd2; bus_a.memIn = 8'h77;
      tick();
      check("clr_acc_valid", 32'(bus_a.memValid), 0);
      check("clr_acc_error", 32'(bus_a.memError), 0);
      check("clr_acc_out",   32'(bus_a.memOut), 32'h C3);
      for (int i = 0; i < 256; i++) begin
         check("clr_ready", 32'(bus_a.memReady), 0);
         check("clr_valid", 32'(bus_a.memValid), 0);
         tick();
      end
      bus_a.memClear = 1'b0; bus_a.memWrite = 1'b0; bus_a.memRead = 1'b0;
      check("clr_ready_after", 32'(bus_a.memReady), 1);
      check("clr_out_hold",    32'(bus_a.memOut), 32'h C3);
      bus_a.memRead = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_a.lineNumber = 8'(k);
         tick();
         check("clr_zero_out",   32'(bus_a.memOut), 0);
         check("clr_zero_valid", 32'(bus_a.memValid), 1);
      end
      bus_a.memRead = 1'b0;

      // Reset mid-sweep: memOut nonzero beforehand so the abort is visible.
      bus_a.memWrite = 1'b1; bus_a.lineNumber = 8'd3; bus_a.memIn = 8'h5A;
      tick();
      bus_a.memWrite = 1'b0; bus_a.memRead = 1'b1;
      tick();
      bus_a.memRead = 1'b0;
      check("pre_rst_out", 32'(bus_a.memOut), 32'h 5A);
      bus_a.memClear = 1'b1;
      tick();
      bus_a.memClear = 1'b0;
      for (int i = 0; i < 50; i++) tick();
      check("mid_sweep_ready", 32'(bus_a.memReady), 0);
      check("mid_sweep_out",   32'(bus_a.memOut), 32'h 5A);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_out",     32'(bus_a.memOut), 0);
      check("mid_rst_valid",   32'(bus_a.memValid), 0);
      check("mid_rst_ready",   32'(bus_a.memReady), 0);
      check("mid_rst_error",   32'(bus_a.memError), 0);
      check("mid_rst_ready_b", 32'(bus_b.memReady), 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         check("resweep_ready_a", 32'(bus_a.memReady), 0);
         check("resweep_ready_b", 32'(bus_b.memReady), 32'(i >= 200));
         tick();
      end
      check("resweep_ready_after", 32'(bus_a.memReady), 1);
      bus_a.memRead = 1'b1; bus_a.lineNumber = 8'd3;
      tick();
      bus_a.memRead = 1'b0;
      check("resweep_line3", 32'(bus_a.memOut), 0);

      // DEPTH=200: out-of-range accesses.
      bus_b.memWrite = 1'b1; bus_b.lineNumber = 8'd10; bus_b.memIn = 8'h42;
      tick();
      bus_b.memWrite = 1'b0; bus_b.memRead = 1'b1;
      tick();
      check("oor_pre_out", 32'(bus_b.memOut), 32'h 42);
      check("oor_pre_err", 32'(bus_b.memError), 0);
      bus_b.memRead = 1'b0; bus_b.memWrite = 1'b1;
      bus_b.lineNumber = 8'd210; bus_b.memIn = 8'hFF;
      tick();
      check("oor_wr_err",   32'(bus_b.memError), 1);
      check("oor_wr_valid", 32'(bus_b.memValid), 0);
      check("oor_wr_out",   32'(bus_b.memOut), 32'h 42);
      bus_b.memWrite = 1'b0; bus_b.memRead = 1'b1;
      tick();
      check("oor_rd_out",   32'(bus_b.memOut), 0);
      check("oor_rd_valid", 32'(bus_b.memValid), 1);
      check("oor_rd_err",   32'(bus_b.memError), 1);
      bus_b.memRead = 1'b0;
      tick();
      check("oor_err_drop",   32'(bus_b.memError), 0);
      check("oor_valid_drop", 32'(bus_b.memValid), 0);
      bus_b.memRead = 1'b1; bus_b.lineNumber = 8'd10;
      tick();
      check("oor_line10", 32'(bus_b.memOut), 32'h 42);
      bus_b.lineNumber = 8'd199;
      tick();
      check("last_line_out", 32'(bus_b.memOut), 0);
      check("last_line_err", 32'(bus_b.memError), 0);
      bus_b.lineNumber = 8'd10;
      tick();
      check("line10_again", 32'(bus_b.memOut), 32'h 42);
      bus_b.lineNumber = 8'd200;
      tick();
      bus_b.memRead = 1'b0;
      check("first_oor_out",   32'(bus_b.memOut), 0);
      check("first_oor_err",   32'(bus_b.memError), 1);
      check("first_oor_valid", 32'(bus_b.memValid), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_data_memory.md
# sync_data_memory

Parametrised synchronous data memory for the datapath's load/store stage; successor to the fixed 8-bit × 256-line asynchronous data memory. It adds a clock, a registered read port with a valid strobe, and a hardware clear sequencer that zeroes every line after reset or on request. It also flags out-of-range accesses and exposes a ready signal so the control unit can stall while the memory is clearing.

## Interface
- DATA_WIDTH, 8, bits per line
- ADDR_WIDTH, 8, width of lineNumber
- DEPTH, 256, number of implemented lines; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH
- clk  input  1  clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- memIn  input  DATA_WIDTH  write data
- lineNumber  input  ADDR_WIDTH  line address for read and write
- memRead  input  1  read request, sampled when memReady=1
- memWrite  input  1  write request, sampled when memReady=1
- memClear  input  1  request a full zeroing sweep, sampled when memReady=1
- memOut  output  DATA_WIDTH  registered read data; holds its value between reads
- memValid  output  1  one-cycle pulse: memOut was updated this cycle
- memReady  output  1  high when requests are accepted (state IDLE)
- memError  output  1  one-cycle pulse: the previous accepted access had lineNumber ≥ DEPTH

## Operation
- One clock; reset is asynchronous and active-high.
- FSM has two states, CLEAR and IDLE. A clear pointer clrPtr counts 0 to DEPTH-1 and is ceil(log2(DEPTH)) bits wide, minimum 1.
- Reset asserted: state=CLEAR, clrPtr=0, memOut=0, memValid=0, memReady=0, memError=0. The array itself is not reset asynchronously.
- CLEAR behaviour:
  - Each edge writes 0 to line clrPtr and increments clrPtr.
  - On the edge that writes line DEPTH-1, clrPtr returns to 0 and state becomes IDLE.
  - memRead, memWrite and memClear are ignored.
- IDLE, priority memClear > access:
  - memClear=1: state becomes CLEAR and clrPtr=0. Any memRead or memWrite in the same cycle is dropped, with no memValid and no memError.
  - memWrite=1 with lineNumber < DEPTH: the line is written with memIn.
  - memRead=1 with lineNumber < DEPTH: memOut gets the line contents, and memValid=1 on the following cycle.
  - Read and write in the same cycle to the same line use write-first ordering: memOut equals memIn.
  - lineNumber ≥ DEPTH: the write is dropped; a read loads memOut=0 with memValid=1; memError=1 on the following cycle if either request was high.
- memReady is registered: it equals (state==IDLE).
- Reset asserted mid-sweep or mid-access aborts immediately. The sweep restarts from line 0 after reset is released.

## Timing
- Clear sweep takes exactly DEPTH rising edges after reset is released, or after the edge that accepts memClear. memReady rises after the DEPTH-th edge.
- Write latency: the written data is visible to a read issued on the next cycle.
- Read latency is 1 cycle: request at edge N, so memOut and memValid are valid after edge N+1.
- Back-to-back reads every cycle give memValid held high continuously.
- memError has the same 1-cycle latency as memValid and is never high in CLEAR.
- memOut is unchanged on cycles without an accepted read, including throughout CLEAR.

## Test plan
- Reset and clear with DEPTH=256: assert reset, then release. memReady must be 0 for 256 edges and 1 afterwards. Reads of lines 0, 128 and 255 must return 0 with memValid pulsing once per read.
- Write/read: write 0xA5 to line 3, then read line 3 on the next cycle. memOut=0xA5 and memValid=1 exactly one cycle after the read.
- Same-cycle read and write: with line 7 holding 0x11, issue memWrite and memRead together with memIn=0x3C. memOut must be 0x3C.
- Out of range with DEPTH=200, ADDR_WIDTH=8: write 0xFF to line 210, then read line 210. memOut=0, memValid=1, and memError pulses on both accesses. Line 210 mod 200 (line 10) is unchanged.
- memClear: fill lines 0–3 with nonzero values, then pulse memClear together with a memWrite. memReady must be low for DEPTH cycles, the write must be dropped, and all of lines 0–3 must read back 0.
- Reset mid-sweep: assert reset at edge 50 of a sweep. All outputs must be 0 immediately. After release, a fresh sweep of DEPTH cycles must run before memReady=1.
